// File: rtl/pc_redirect_unit.sv
// Fetch PC register with branch/jump redirect, stall hold and one-cycle flush generation.
// Redirect targets are word-aligned on load; misaligned requests raise a sticky error flag.
module pc_redirect_unit #(
   parameter int unsigned          WIDTH     = 32,
   parameter logic [WIDTH-1:0]     RESET_PC  = '0,
   parameter int unsigned          CNT_WIDTH = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Stall,
   input  logic                 BranchTaken,
   input  logic [WIDTH-1:0]     BranchTarget,
   input  logic                 Jump,
   input  logic [WIDTH-1:0]     JumpTarget,
   output logic [WIDTH-1:0]     PC,
   output logic [WIDTH-1:0]     PCPlus4,
   output logic                 FlushIF,
   output logic                 FlushID,
   output logic [1:0]           State,
   output logic [CNT_WIDTH-1:0] TakenCount,
   output logic                 AlignErr
);

   typedef enum logic [1:0] {
      ST_FETCH    = 2'd0,
      ST_HOLD     = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_ILLEGAL  = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       pc_q, pc_d;
   logic                   br_flag_q, br_flag_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   align_q, align_d;
   logic                   flush_if_q, flush_if_d;
   logic                   flush_id_q, flush_id_d;
   logic [WIDTH-1:0]       pc_inc_c;
   logic [WIDTH-1:0]       br_tgt_c;
   logic [WIDTH-1:0]       j_tgt_c;

   assign pc_inc_c = pc_q + WIDTH'(4);
   assign br_tgt_c = {BranchTarget[WIDTH-1:2], 2'b00};
   assign j_tgt_c  = {JumpTarget[WIDTH-1:2], 2'b00};

   // Next-state, next-PC and bookkeeping; flushes are Moore outputs of the next state.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      br_flag_d = br_flag_q;
      cnt_d     = cnt_q;
      align_d   = align_q;

      case (state_q)
         ST_FETCH, ST_HOLD: begin
            if (BranchTaken) begin
               pc_d      = br_tgt_c;
               br_flag_d = 1'b1;
               align_d   = align_q | (|BranchTarget[1:0]);
               if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
               state_d   = ST_REDIRECT;
            end else if (Jump) begin
               pc_d      = j_tgt_c;
               br_flag_d = 1'b0;
               align_d   = align_q | (|JumpTarget[1:0]);
               state_d   = ST_REDIRECT;
            end else if (Stall) begin
               state_d   = ST_HOLD;
            end else begin
               pc_d      = pc_inc_c;
               state_d   = ST_FETCH;
            end
         end
         // Requests seen here belong to squashed instructions and are dropped.
         ST_REDIRECT: begin
            if (Stall) begin
               state_d = ST_HOLD;
            end else begin
               pc_d    = pc_inc_c;
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase

      flush_if_d = (state_d == ST_REDIRECT);
      flush_id_d = (state_d == ST_REDIRECT) && br_flag_d;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         br_flag_q  <= 1'b0;
         cnt_q      <= '0;
         align_q    <= 1'b0;
         flush_if_q <= 1'b0;
         flush_id_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         br_flag_q  <= br_flag_d;
         cnt_q      <= cnt_d;
         align_q    <= align_d;
         flush_if_q <= flush_if_d;
         flush_id_q <= flush_id_d;
      end
   end

   assign PC         = pc_q;
   assign PCPlus4    = pc_inc_c;
   assign FlushIF    = flush_if_q;
   assign FlushID    = flush_id_q;
   assign State      = state_q;
   assign TakenCount = cnt_q;
   assign AlignErr   = align_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed vector table, hand sequences and a random run
// checked against a cycle-level behavioural model of the fetch redirect rules.
module tb_pc_redirect_unit;

   logic        Clk;
   logic        Reset;
   logic        Stall;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [31:0] JumpTarget;

   logic [31:0] pc, pcp4;
   logic        fif, fid, al;
   logic [1:0]  st;
   logic [15:0] cnt;

   logic [31:0] s_pc, s_pcp4;
   logic        s_fif, s_fid, s_al;
   logic [1:0]  s_st;
   logic [1:0]  s_cnt;

   int n_chk = 0;
   int n_err = 0;

   pc_redirect_unit u_dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Jump(Jump), .JumpTarget(JumpTarget),
      .PC(pc), .PCPlus4(pcp4), .FlushIF(fif), .FlushID(fid),
      .State(st), .TakenCount(cnt), .AlignErr(al)
   );

   pc_redirect_unit #(.CNT_WIDTH(2)) u_sat (
      .Clk(Clk), .Reset(Reset), .Stall(Stall),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Jump(Jump), .JumpTarget(JumpTarget),
      .PC(s_pc), .PCPlus4(s_pcp4), .FlushIF(s_fif), .FlushID(s_fid),
      .State(s_st), .TakenCount(s_cnt), .AlignErr(s_al)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural model: "in the flush cycle" and "held" are tracked as plain flags.
   logic [31:0] m_pc;
   bit          m_redir, m_hold, m_fif, m_fid, m_al;
   int          m_cnt;

   task automatic model_reset();
      m_pc = 32'h0; m_redir = 0; m_hold = 0; m_fif = 0; m_fid = 0; m_al = 0; m_cnt = 0;
   endtask

   task automatic model_step(input bit stall, input bit bt, input logic [31:0] btgt,
                             input bit j, input logic [31:0] jtgt);
      if (m_redir) begin
         m_redir = 0; m_fif = 0; m_fid = 0;
         if (!stall) m_pc = m_pc + 32'd4;
         m_hold = stall;
      end else if (bt || j) begin
         logic [31:0] t;
         t = bt ? btgt : jtgt;
         m_pc = t & 32'hFFFF_FFFC;
         if (t[1:0] != 2'b00) m_al = 1;
         if (bt && m_cnt < 65535) m_cnt++;
         m_redir = 1; m_hold = 0; m_fif = 1; m_fid = bt;
      end else if (stall) begin
         m_hold = 1;
      end else begin
         m_pc = m_pc + 32'd4;
         m_hold = 0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] e_st;
      e_st = m_redir ? 32'd2 : (m_hold ? 32'd1 : 32'd0);
      chk({tag, " pc"},      pc,          m_pc);
      chk({tag, " pcp4"},    pcp4,        m_pc + 32'd4);
      chk({tag, " state"},   32'(st),     e_st);
      chk({tag, " flushif"}, 32'(fif),    32'(m_fif));
      chk({tag, " flushid"}, 32'(fid),    32'(m_fid));
      chk({tag, " count"},   32'(cnt),    32'(m_cnt));
      chk({tag, " align"},   32'(al),     32'(m_al));
      chk({tag, " sat_pc"},  s_pc,        m_pc);
      chk({tag, " sat_st"},  32'(s_st),   e_st);
      chk({tag, " sat_fid"}, 32'(s_fid),  32'(m_fid));
      chk({tag, " sat_cnt"}, 32'(s_cnt),  32'((m_cnt > 3) ? 3 : m_cnt));
      chk({tag, " sat_al"},  32'(s_al),   32'(m_al));
   endtask

   // Apply inputs at the falling edge, advance one rising edge, return at the next falling edge.
   task automatic cycle(input bit stall, input bit bt, input logic [31:0] btgt,
                        input bit j, input logic [31:0] jtgt);
      Stall = stall; BranchTaken = bt; BranchTarget = btgt; Jump = j; JumpTarget = jtgt;
      @(posedge Clk);
      model_step(stall, bt, btgt, j, jtgt);
      @(negedge Clk);
   endtask

   typedef struct packed {
      logic        stall;
      logic        bt;
      logic [31:0] btgt;
      logic        j;
      logic [31:0] jtgt;
      logic [31:0] pc;
      logic [1:0]  st;
      logic        fif;
      logic        fid;
      logic [15:0] cnt;
      logic        al;
   } vec_t;

   function automatic vec_t mk(input bit stall, input bit bt, input logic [31:0] btgt,
                               input bit j, input logic [31:0] jtgt, input logic [31:0] epc,
                               input int est, input bit efif, input bit efid,
                               input int ecnt, input bit eal);
      vec_t v;
      v.stall = stall; v.bt = bt; v.btgt = btgt; v.j = j; v.jtgt = jtgt;
      v.pc = epc; v.st = 2'(est); v.fif = efif; v.fid = efid; v.cnt = 16'(ecnt); v.al = eal;
      return v;
   endfunction

   localparam int unsigned NVEC = 19;
   vec_t vec [NVEC];

   initial begin
      //           stall bt btgt          j  jtgt          pc            st fif fid cnt al
      vec[0]  = mk(0,    0, 32'h0,        0, 32'h0,        32'h4,        0, 0,  0,  0,  0);
      vec[1]  = mk(0,    0, 32'h0,        0, 32'h0,        32'h8,        0, 0,  0,  0,  0);
      vec[2]  = mk(0,    0, 32'h0,        0, 32'h0,        32'hC,        0, 0,  0,  0,  0);
      vec[3]  = mk(0,    0, 32'h0,        0, 32'h0,        32'h10,       0, 0,  0,  0,  0);
      vec[4]  = mk(0,    1, 32'h40,       0, 32'h0,        32'h40,       2, 1,  1,  1,  0);
      vec[5]  = mk(0,    0, 32'h0,        0, 32'h0,        32'h44,       0, 0,  0,  1,  0);
      vec[6]  = mk(1,    0, 32'h0,        1, 32'h100,      32'h100,      2, 1,  0,  1,  0);
      vec[7]  = mk(1,    0, 32'h0,        0, 32'h0,        32'h100,      1, 0,  0,  1,  0);
      vec[8]  = mk(1,    0, 32'h0,        0, 32'h0,        32'h100,      1, 0,  0,  1,  0);
      vec[9]  = mk(0,    0, 32'h0,        0, 32'h0,        32'h104,      0, 0,  0,  1,  0);
      vec[10] = mk(0,    1, 32'h200,      1, 32'h300,      32'h200,      2, 1,  1,  2,  0);
      vec[11] = mk(0,    1, 32'h500,      0, 32'h0,        32'h204,      0, 0,  0,  2,  0);
      vec[12] = mk(0,    1, 32'h43,       0, 32'h0,        32'h40,       2, 1,  1,  3,  1);
      vec[13] = mk(0,    0, 32'h0,        0, 32'h0,        32'h44,       0, 0,  0,  3,  1);
      vec[14] = mk(1,    0, 32'h0,        0, 32'h0,        32'h44,       1, 0,  0,  3,  1);
      vec[15] = mk(1,    1, 32'h80,       0, 32'h0,        32'h80,       2, 1,  1,  4,  1);
      vec[16] = mk(1,    0, 32'h0,        0, 32'h0,        32'h80,       1, 0,  0,  4,  1);
      vec[17] = mk(0,    0, 32'h0,        1, 32'h10,       32'h10,       2, 1,  0,  4,  1);
      vec[18] = mk(0,    0, 32'h0,        0, 32'h0,        32'h14,       0, 0,  0,  4,  1);

      Reset = 1'b0; Stall = 0; BranchTaken = 0; Jump = 0; BranchTarget = '0; JumpTarget = '0;
      model_reset();
      repeat (2) @(negedge Clk);
      chk("reset pc",    pc,       32'h0);
      chk("reset state", 32'(st),  32'd0);
      chk("reset flush", 32'({fif, fid}), 32'd0);
      chk("reset count", 32'(cnt), 32'd0);
      chk("reset align", 32'(al),  32'd0);
      Reset = 1'b1;

      for (int i = 0; i < int'(NVEC); i++) begin
         cycle(vec[i].stall, vec[i].bt, vec[i].btgt, vec[i].j, vec[i].jtgt);
         chk($sformatf("vec%0d pc", i),    pc,         vec[i].pc);
         chk($sformatf("vec%0d pcp4", i),  pcp4,       vec[i].pc + 32'd4);
         chk($sformatf("vec%0d state", i), 32'(st),    32'(vec[i].st));
         chk($sformatf("vec%0d fif", i),   32'(fif),   32'(vec[i].fif));
         chk($sformatf("vec%0d fid", i),   32'(fid),   32'(vec[i].fid));
         chk($sformatf("vec%0d cnt", i),   32'(cnt),   32'(vec[i].cnt));
         chk($sformatf("vec%0d align", i), 32'(al),    32'(vec[i].al));
      end
      chk("sat count after 4 branches", 32'(s_cnt), 32'd3);

      // Sticky alignment flag across ordinary sequential fetch.
      for (int i = 0; i < 10; i++) begin
         cycle(0, 0, 32'h0, 0, 32'h0);
         check_model($sformatf("seq%0d", i));
      end
      chk("align sticky", 32'(al), 32'd1);

      // PC wrap at the top of the address space.
      cycle(0, 0, 32'h0, 1, 32'hFFFF_FFFC);
      chk("wrap pc", pc, 32'hFFFF_FFFC);
      chk("wrap pcp4", pcp4, 32'h0);
      cycle(0, 0, 32'h0, 0, 32'h0);
      chk("wrap next pc", pc, 32'h0);
      check_model("wrap");

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] bt_t, j_t;
         bit s, b, jj;
         bt_t = $urandom; j_t = $urandom;
         if ($urandom_range(0, 7) != 0) bt_t[1:0] = 2'b00;
         if ($urandom_range(0, 7) != 0) j_t[1:0]  = 2'b00;
         s  = ($urandom_range(0, 9) < 3);
         b  = ($urandom_range(0, 9) < 2);
         jj = ($urandom_range(0, 9) < 2);
         cycle(s, b, bt_t, jj, j_t);
         check_model($sformatf("rnd%0d", i));
      end

      // Asynchronous reset landing in the middle of a redirect cycle.
      cycle(0, 1, 32'h0000_0603, 0, 32'h0);
      chk("pre-reset state", 32'(st), 32'd2);
      chk("pre-reset align", 32'(al), 32'd1);
      #2 Reset = 1'b0;
      #1;
      chk("async reset pc",    pc,             32'h0);
      chk("async reset flush", 32'({fif, fid}), 32'd0);
      chk("async reset state", 32'(st),        32'd0);
      chk("async reset align", 32'(al),        32'd0);
      chk("async reset count", 32'(cnt),       32'd0);
      model_reset();
      @(negedge Clk);
      Reset = 1'b1;
      cycle(0, 0, 32'h0, 0, 32'h0);
      chk("post-reset pc", pc, 32'h4);
      check_model("post-reset");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
